// File: rtl/timer0_csr.sv
// Timer0 CSR block: LiteX-style down-counting timer behind a Wishbone secondary port.
// One-cycle ack handshake, latched counter readback and a level zero-event interrupt.
module timer0_csr #(
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] dat_o_p,
  output logic [31:0] dat_o_s,
  output logic        ack,
  output logic        interrupt
);

  localparam int unsigned CW = COUNTER_WIDTH;
  localparam int unsigned DW = 32;

  localparam logic [2:0] IDX_LOAD    = 3'd0;
  localparam logic [2:0] IDX_RELOAD  = 3'd1;
  localparam logic [2:0] IDX_EN      = 3'd2;
  localparam logic [2:0] IDX_UPDATE  = 3'd3;
  localparam logic [2:0] IDX_VALUE   = 3'd4;
  localparam logic [2:0] IDX_STATUS  = 3'd5;
  localparam logic [2:0] IDX_PENDING = 3'd6;
  localparam logic [2:0] IDX_ENABLE  = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] load;
  logic [CW-1:0] reload;
  logic [CW-1:0] value;
  logic [CW-1:0] cnt;
  logic          en;
  logic          ev_pending;
  logic          ev_enable;
  logic          zero;
  logic          zero_d;
  logic          wr;

  // Ack FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ack FSM: accept in IDLE, ack for one cycle, always return to IDLE
  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    case (state)
      IDLE: begin
        if (cyc && stb) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign wr   = cyc & stb & we & (state == IDLE);
  assign zero = (cnt == '0);

  // Software-writable registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load      <= '0;
      reload    <= '0;
      en        <= 1'b0;
      ev_enable <= 1'b0;
    end else if (wr) begin
      case (addr)
        IDX_LOAD:   load      <= CW'(dat_o_p);
        IDX_RELOAD: reload    <= CW'(dat_o_p);
        IDX_EN:     en        <= dat_o_p[0];
        IDX_ENABLE: ev_enable <= dat_o_p[0];
        default: ;
      endcase
    end
  end

  // Down counter; zero is absorbed by the reload branch so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= load;
    end else if (zero) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  // Snapshot of the counter taken on an update_value strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (wr && (addr == IDX_UPDATE)) begin
      value <= cnt;
    end
  end

  // Rising-edge zero detector; zero_d starts high so reset itself is not an event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_d     <= 1'b1;
      ev_pending <= 1'b0;
    end else begin
      zero_d <= zero;
      if (zero && !zero_d) begin
        ev_pending <= 1'b1;
      end else if (wr && (addr == IDX_PENDING) && dat_o_p[0]) begin
        ev_pending <= 1'b0;
      end
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    dat_o_s = '0;
    case (addr)
      IDX_LOAD:    dat_o_s = DW'(load);
      IDX_RELOAD:  dat_o_s = DW'(reload);
      IDX_EN:      dat_o_s = DW'(en);
      IDX_UPDATE:  dat_o_s = '0;
      IDX_VALUE:   dat_o_s = DW'(value);
      IDX_STATUS:  dat_o_s = DW'(zero);
      IDX_PENDING: dat_o_s = DW'(ev_pending);
      IDX_ENABLE:  dat_o_s = DW'(ev_enable);
      default:     dat_o_s = '0;
    endcase
  end

  assign interrupt = ev_pending & ev_enable;

endmodule

// File: doc/timer0_csr.md
# timer0_csr

LiteX-compatible down-counting timer peripheral for the CSR region at 0xF000_1800. It replaces the plain read/write storage currently held for Timer0 in `csr_and_clint`. The interconnect routes Timer0-addressed Wishbone cycles to this block, passing the word address `addr[4:2]`. The block returns read data and ack, and drives a level interrupt toward the interrupt controller.

## Interface
- `COUNTER_WIDTH`, default 32: counter width, 1..32.
  - `load`, `reload`, `value` and the latched value hold `COUNTER_WIDTH` bits.
  - Read-data bits above `COUNTER_WIDTH` return 0.
- `wb_if_s.clock` (input, 1): the single clock; all state updates on the rising edge.
- `wb_if_s.reset` (input, 1): asynchronous, active-high reset.
- `wb_if_s` is a `wishbone_if.secondary` with DATA_SIZE=32, ADDR_SIZE=3 and BYTE_SIZE=8. Signals used:
  - `cyc`, `stb`, `we`, `addr[2:0]` (word index), `dat_o_p[31:0]`: inputs.
  - `dat_o_s[31:0]`, `ack`: outputs.
  - `sel` and `tgd` are ignored; every write is a full-word write.
- `interrupt` (output, 1): level interrupt, equal to `ev_pending & ev_enable`.

## Operation
- Register map, by word index:
  - 0 `load` (RW)
  - 1 `reload` (RW)
  - 2 `en` (RW, bit 0)
  - 3 `update_value` (WO, strobe)
  - 4 `value` (RO, latched)
  - 5 `ev_status` (RO, bit 0)
  - 6 `ev_pending` (RW1C, bit 0)
  - 7 `ev_enable` (RW, bit 0)
- Write enable is `cyc & stb & we`, sampled while the ack FSM is in IDLE. A write takes effect at the sampling edge.
- Writes to `value` and `ev_status` are ignored. Reads of `update_value` return 0.
- Counter `cnt` updates every edge:
  - `en=0`: `cnt <= load`.
  - `en=1` and `cnt==0`: `cnt <= reload`.
  - `en=1` and `cnt!=0`: `cnt <= cnt-1`, modulo 2^`COUNTER_WIDTH`. It never underflows, because zero is handled by the reload branch.
- Modes:
  - One-shot: `reload=0`. The counter stops at 0.
  - Periodic: `reload=N`. The period is N+1 cycles.
- Any write to `update_value` latches `cnt` into `value` at that edge. `value` holds the pre-update counter contents; `cnt` is not software-visible otherwise.
- Zero event:
  - `zero = (cnt==0)`; `zero_d` is `zero` registered.
  - `ev_status` reads `zero` combinationally.
  - `ev_pending` sets at the edge where `zero & ~zero_d`, i.e. one edge after `cnt` reaches 0.
  - Writing 1 to `ev_pending` bit 0 clears it. If a clear and a set occur at the same edge, the set wins.
- Ack FSM:
  - IDLE: if `cyc & stb`, go to ACK.
  - ACK: drive `ack=1` for exactly one cycle, then return to IDLE unconditionally.
  - A request held high across ACK is therefore accepted again on the following IDLE cycle. The primary drops `stb` on `ack`.
- `dat_o_s` is combinational from `addr` and the current register state. It is valid whenever `ack=1`.

## Timing
- Reset values:
  - All registers 0: `load`, `reload`, `en`, `value`, `ev_pending`, `ev_enable`, `cnt`.
  - `zero_d` resets to 1, so no event is raised after reset.
  - FSM in IDLE.
  - Outputs: `ack=0`, `interrupt=0`, `dat_o_s` equal to the register selected by `addr` (0 after reset).
- Access latency: a request sampled at edge E gets `ack` high in cycle E..E+1; read data is valid in that same cycle.
- Enable: a write of `en=1` at edge E makes E+1 the first decrement edge. `cnt` equals `load` at E because `en` was still 0.
- Writing `load` while `en=1` has no effect until the next time `en` is 0.
- Interrupt latency: `cnt` becomes 0 at edge Z, `ev_pending` sets at Z+1, and `interrupt` rises in the cycle after Z+1 (combinational from registers).
- Reset asserted mid-transaction clears the FSM immediately. `ack` falls asynchronously and the write is lost.

## Test plan
- **Reset.** Assert reset for 3 cycles mid-access. Required: `ack=0`, `interrupt=0`, every register reads 0, `ev_status` reads 1.
- **One-shot.** Write `load=3`, `reload=0`, `ev_enable=1`, then `en=1`. Required:
  - `cnt` goes 3, 2, 1, 0 over 3 edges after enable, then stays 0.
  - `ev_pending=1` one edge after reaching 0, with `interrupt=1`.
  - After writing `ev_pending=1`: `ev_pending=0` and `interrupt=0`, with no re-trigger while `cnt` stays 0.
- **Periodic.** Write `load=2`, `reload=4`, `en=1`, then run 20 cycles. Required: zero events 5 cycles apart, and `ev_pending` re-sets after each clear.
- **Latch.** Write `load=100` and `en=1`, wait 10 cycles, write `update_value`, then read `value`. Required: `value` equals the `cnt` at the write edge (89 for this bench's fixed write timing). Writes to index 4 do not change `value`.
- **Clear/set collision.** Clear `ev_pending` on the same edge a zero event is detected. Required: `ev_pending` remains 1.
- **Handshake.** Back-to-back read and write with `stb` held high for 4 cycles. Required: `ack` pattern 0,1,0,1, one access per ack. `ev_enable=0` keeps `interrupt=0` while `ev_pending=1`.
